// File: rtl/gradient_controller_pkg.sv
// Shared definitions for the gradient-descent training controller.
//   - FSM state encoding used by gradient_controller
//   - fixed-point word geometry: 10.10 data words, 32-bit accumulators
//   - fx_mul: signed 10.10 x 10.10 multiply, realigned back to 10.10
package gradient_controller_pkg;

  localparam int WORD_W = 20;
  localparam int FRAC_W = 10;
  localparam int ACC_W  = 32;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FETCH,
    EVAL,
    UPDATE,
    DONE
  } state_t;

  // Full 40-bit signed product, then keep bits [29:10] so the result is
  // 10.10 again. Integer overflow above bit 29 is discarded.
  function automatic logic [WORD_W-1:0] fx_mul(input logic signed [WORD_W-1:0] a,
                                               input logic signed [WORD_W-1:0] b);
    logic signed [2*WORD_W-1:0] p;
    p = a * b;
    return WORD_W'(p >>> FRAC_W);
  endfunction

endpackage

// File: rtl/gradient_controller_grad_accumulator.sv
// grad_accumulator: per-epoch gradient sums for the training controller.
//   clk, reset       : clock and synchronous active-high reset
//   clr              : zero both sums (start of an epoch)
//   acc_en           : add the current sample's contribution
//   err, x           : error (Y - h) and feature of the current sample, 10.10
//   delta_b0/delta_b1: sums scaled by the learning rate, truncated to 20 bits
module grad_accumulator
  import gradient_controller_pkg::*;
#(
  parameter int LR_SHIFT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              acc_en,
  input  logic [WORD_W-1:0] err,
  input  logic [WORD_W-1:0] x,
  output logic [WORD_W-1:0] delta_b0,
  output logic [WORD_W-1:0] delta_b1
);

  logic signed [ACC_W-1:0]  sum_e_reg;
  logic signed [ACC_W-1:0]  sum_ex_reg;
  logic        [WORD_W-1:0] ex_term;

  assign ex_term = fx_mul(err, x);

  // Sums wrap silently; a 32-bit range is ample for 255 samples of 10.10.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      sum_e_reg  <= '0;
      sum_ex_reg <= '0;
    end else if (acc_en) begin
      sum_e_reg  <= sum_e_reg  + {{(ACC_W-WORD_W){err[WORD_W-1]}}, err};
      sum_ex_reg <= sum_ex_reg + {{(ACC_W-WORD_W){ex_term[WORD_W-1]}}, ex_term};
    end
  end

  // Arithmetic shift keeps negative gradients negative for any shift amount.
  assign delta_b0 = WORD_W'(sum_e_reg >>> LR_SHIFT);
  assign delta_b1 = WORD_W'(sum_ex_reg >>> LR_SHIFT);

endmodule

// File: rtl/gradient_controller.sv
// gradient_controller: batch gradient-descent trainer for h = b0 + b1*x.
// Walks the dataset once per epoch, accumulates err and err*x, then moves
// b0/b1 by the learning-rate-scaled sums. Repeats for EPOCHS epochs.
//   clk, reset        : clock, synchronous active-high reset
//   start             : run request (honoured only in IDLE)
//   mem_addr          : dataset read address (memory has 1-cycle read latency)
//   mem_x, mem_y      : dataset read data, unsigned 10.10
//   x_out, y_out      : registered sample presented to the error checker
//   err               : error checker result Y - h, signed 10.10
//   ec_en, ec_init    : error checker enable / log restart
//   b0, b1            : current coefficients, 10.10
//   epoch             : completed epochs in the current/last run
//   busy, done        : run in progress / one-cycle completion pulse
module gradient_controller
  import gradient_controller_pkg::*;
#(
  parameter int N_SAMPLES = 150,
  parameter int EPOCHS    = 100,
  parameter int LR_SHIFT  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [7:0]        mem_addr,
  input  logic [WORD_W-1:0] mem_x,
  input  logic [WORD_W-1:0] mem_y,
  output logic [WORD_W-1:0] x_out,
  output logic [WORD_W-1:0] y_out,
  input  logic [WORD_W-1:0] err,
  output logic              ec_en,
  output logic              ec_init,
  output logic [WORD_W-1:0] b0,
  output logic [WORD_W-1:0] b1,
  output logic [7:0]        epoch,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] LAST_IDX  = 8'(N_SAMPLES - 1);
  localparam logic [7:0] EPOCH_END = 8'(EPOCHS);

  state_t            state_reg, state_next;
  logic [7:0]        index_reg;
  logic [7:0]        addr_reg;
  logic [7:0]        epoch_reg;
  logic [7:0]        epoch_inc;
  logic [WORD_W-1:0] x_reg, y_reg, b0_reg, b1_reg;
  logic              acc_clr, acc_en;
  logic [WORD_W-1:0] delta_b0, delta_b1;

  assign epoch_inc = epoch_reg + 8'd1;

  grad_accumulator #(
    .LR_SHIFT(LR_SHIFT)
  ) u_acc (
    .clk     (clk),
    .reset   (reset),
    .clr     (acc_clr),
    .acc_en  (acc_en),
    .err     (err),
    .x       (x_reg),
    .delta_b0(delta_b0),
    .delta_b1(delta_b1)
  );

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    ec_en      = 1'b0;
    ec_init    = 1'b0;
    acc_clr    = 1'b0;
    acc_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = INIT;
      end
      INIT: begin
        busy       = 1'b1;
        acc_clr    = 1'b1;
        // epoch is still 0 only during the first epoch of a run
        ec_init    = (epoch_reg == 8'd0);
        state_next = FETCH;
      end
      FETCH: begin
        busy       = 1'b1;
        state_next = EVAL;
      end
      EVAL: begin
        busy       = 1'b1;
        ec_en      = 1'b1;
        acc_en     = 1'b1;
        state_next = (index_reg == LAST_IDX) ? UPDATE : FETCH;
      end
      UPDATE: begin
        busy       = 1'b1;
        state_next = (epoch_inc == EPOCH_END) ? DONE : INIT;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      index_reg <= '0;
      addr_reg  <= '0;
      epoch_reg <= '0;
      x_reg     <= '0;
      y_reg     <= '0;
      b0_reg    <= '0;
      b1_reg    <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (start) begin
            epoch_reg <= '0;
            b0_reg    <= '0;
            b1_reg    <= '0;
            index_reg <= '0;
            addr_reg  <= '0;
          end
        end
        FETCH: begin
          x_reg    <= mem_x;
          y_reg    <= mem_y;
          // The memory needs the next address one cycle ahead of the next
          // FETCH, so advance it here; it is 0 again when the epoch ends.
          addr_reg <= (index_reg == LAST_IDX) ? 8'd0 : index_reg + 8'd1;
        end
        EVAL: begin
          index_reg <= (index_reg == LAST_IDX) ? 8'd0 : index_reg + 8'd1;
        end
        UPDATE: begin
          b0_reg    <= b0_reg + delta_b0;
          b1_reg    <= b1_reg + delta_b1;
          epoch_reg <= epoch_inc;
        end
        default: ;
      endcase
    end
  end

  assign mem_addr = addr_reg;
  assign x_out    = x_reg;
  assign y_out    = y_reg;
  assign b0       = b0_reg;
  assign b1       = b1_reg;
  assign epoch    = epoch_reg;

endmodule

// File: tb/tb_gradient_controller.sv
// Directed bench for gradient_controller. Five instances with different
// N_SAMPLES/EPOCHS/LR_SHIFT each get a dataset memory and an error-checker model.
module tb_gradient_controller;
  import gradient_controller_pkg::*;

  localparam int NI = 5;
  localparam int P_N [NI] = '{2, 2, 2, 3, 2};
  localparam int P_E [NI] = '{1, 1, 3, 2, 1};
  localparam int P_L [NI] = '{0, 2, 0, 0, 13};

  logic        clk = 1'b0;
  logic        reset;
  logic        start    [NI];
  logic [7:0]  mem_addr [NI];
  logic [19:0] x_out    [NI];
  logic [19:0] y_out    [NI];
  logic [19:0] err      [NI];
  logic        ec_en    [NI];
  logic        ec_init  [NI];
  logic [19:0] b0       [NI];
  logic [19:0] b1       [NI];
  logic [7:0]  epoch    [NI];
  logic        busy     [NI];
  logic        done     [NI];

  logic [19:0] ds_x [NI][4];
  logic [19:0] ds_y [NI][4];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Error checker: err = Y - (b0 + b1*X), all 10.10, wrapping at 20 bits.
  function automatic logic [19:0] ec_model(input logic [19:0] x, input logic [19:0] y,
                                           input logic [19:0] c0, input logic [19:0] c1);
    logic signed [39:0] p;
    logic [19:0] h;
    p = $signed(c1) * $signed(x);
    h = c0 + 20'(p >>> 10);
    return y - h;
  endfunction

  for (genvar gi = 0; gi < NI; gi++) begin : g_inst
    logic [19:0] mx_reg, my_reg;
    int unsigned dcnt = 0;
    int unsigned en_cnt = 0;
    int unsigned init_cnt = 0;
    int unsigned both_cnt = 0;

    always @(posedge clk) begin
      mx_reg <= ds_x[gi][mem_addr[gi][1:0]];
      my_reg <= ds_y[gi][mem_addr[gi][1:0]];
      if (done[gi] === 1'b1) dcnt <= dcnt + 1;
      if (ec_en[gi] === 1'b1) en_cnt <= en_cnt + 1;
      if (ec_init[gi] === 1'b1) init_cnt <= init_cnt + 1;
      if (ec_en[gi] === 1'b1 && ec_init[gi] === 1'b1) both_cnt <= both_cnt + 1;
    end

    assign err[gi] = ec_model(x_out[gi], y_out[gi], b0[gi], b1[gi]);

    gradient_controller #(
      .N_SAMPLES(P_N[gi]),
      .EPOCHS   (P_E[gi]),
      .LR_SHIFT (P_L[gi])
    ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start[gi]),
      .mem_addr(mem_addr[gi]),
      .mem_x   (mx_reg),
      .mem_y   (my_reg),
      .x_out   (x_out[gi]),
      .y_out   (y_out[gi]),
      .err     (err[gi]),
      .ec_en   (ec_en[gi]),
      .ec_init (ec_init[gi]),
      .b0      (b0[gi]),
      .b1      (b1[gi]),
      .epoch   (epoch[gi]),
      .busy    (busy[gi]),
      .done    (done[gi])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle (or hold it), then count cycles to done.
  // Cycle 1 is the one right after the accepting edge.
  task automatic run_wait(input int i, input bit hold, output int lat);
    start[i] = 1'b1;
    @(posedge clk); #1;
    if (!hold) start[i] = 1'b0;
    lat = 1;
    while (done[i] !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("run inst=%0d latency=%0d b0=0x%05h b1=0x%05h epoch=%0d", i, lat, b0[i], b1[i], epoch[i]);
  endtask

  int          k, lat;
  int unsigned d0, en0, in0;
  logic [19:0] xo1, xo2, b0_e1, b0_e2;
  logic [7:0]  ma1, ep_e1;

  initial begin
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0;
      for (int a = 0; a < 4; a++) begin
        ds_x[i][a] = 20'h0;
        ds_y[i][a] = 20'h0;
      end
    end
    ds_x[0][0] = 20'h00400; ds_y[0][0] = 20'h00800;
    ds_x[0][1] = 20'h00800; ds_y[0][1] = 20'h00C00;
    ds_x[1][0] = 20'h00400; ds_y[1][0] = 20'h00800;
    ds_x[1][1] = 20'h00800; ds_y[1][1] = 20'h00C00;
    ds_y[2][0] = 20'h00400; ds_y[2][1] = 20'h00400;
    ds_y[3][0] = 20'h00200; ds_y[3][1] = 20'h00200; ds_y[3][2] = 20'h00200;
    ds_x[4][0] = 20'h00400; ds_y[4][0] = 20'hFFC00;
    ds_x[4][1] = 20'h00400; ds_y[4][1] = 20'hFFC00;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_mem_addr", 32'(mem_addr[0]), 32'h0);
    check("rst_b0",       32'(b0[0]),       32'h0);
    check("rst_b1",       32'(b1[0]),       32'h0);
    check("rst_epoch",    32'(epoch[0]),    32'h0);
    check("rst_x_out",    32'(x_out[0]),    32'h0);
    check("rst_y_out",    32'(y_out[0]),    32'h0);
    check("rst_busy",     32'(busy[0]),     32'h0);
    check("rst_done",     32'(done[0]),     32'h0);
    check("rst_ec_en",    32'(ec_en[0]),    32'h0);
    check("rst_ec_init",  32'(ec_init[0]),  32'h0);

    // Basic run: sumE = 5.0, sumEX = 8.0, LR_SHIFT = 0
    en0 = g_inst[0].en_cnt; in0 = g_inst[0].init_cnt;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    k = 1;
    check("bas_init_busy",    32'(busy[0]),    32'h1);
    check("bas_init_ec_init", 32'(ec_init[0]), 32'h1);
    while (done[0] !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (k == 3) xo1 = x_out[0];
      if (k == 4) ma1 = mem_addr[0];
      if (k == 5) xo2 = x_out[0];
    end
    $display("run inst=0 latency=%0d b0=0x%05h b1=0x%05h epoch=%0d", k, b0[0], b1[0], epoch[0]);
    check("bas_latency",   32'(k),        32'd7);
    check("bas_x_sample0", 32'(xo1),      32'h00400);
    check("bas_addr_s1",   32'(ma1),      32'h1);
    check("bas_x_sample1", 32'(xo2),      32'h00800);
    check("bas_b0",        32'(b0[0]),    32'h01400);
    check("bas_b1",        32'(b1[0]),    32'h02000);
    check("bas_epoch",     32'(epoch[0]), 32'h1);
    check("bas_done_busy", 32'(busy[0]),  32'h0);
    check("bas_en_count",  g_inst[0].en_cnt - en0,   32'd2);
    check("bas_init_count", g_inst[0].init_cnt - in0, 32'd1);
    @(posedge clk); #1;
    check("bas_done_pulse", 32'(done[0]), 32'h0);
    check("bas_b0_hold",    32'(b0[0]),   32'h01400);

    // Learning-rate shift of 2
    run_wait(1, 1'b0, lat);
    check("lr2_latency", 32'(lat),   32'd7);
    check("lr2_b0",      32'(b0[1]), 32'h00500);
    check("lr2_b1",      32'(b1[1]), 32'h00800);

    // Negative error after a prior epoch: b0 1.5 -> -1.5, wraps to 0xFFA00
    run_wait(3, 1'b0, lat);
    check("neg_latency", 32'(lat),      32'd17);
    check("neg_b0_wrap", 32'(b0[3]),    32'hFFA00);
    check("neg_b1",      32'(b1[3]),    32'h0);
    check("neg_epoch",   32'(epoch[3]), 32'h2);

    // Negative sums shifted by 13: -2048 >>> 13 = -1
    run_wait(4, 1'b0, lat);
    check("ash_latency", 32'(lat),   32'd7);
    check("ash_b0",      32'(b0[4]), 32'hFFFFF);
    check("ash_b1",      32'(b1[4]), 32'hFFFFF);

    // Start held high through a 3-epoch run
    en0 = g_inst[2].en_cnt; in0 = g_inst[2].init_cnt; d0 = g_inst[2].dcnt;
    start[2] = 1'b1;
    @(posedge clk); #1;
    k = 1;
    while (done[2] !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
      if (k == 7) begin b0_e1 = b0[2]; ep_e1 = epoch[2]; end
      if (k == 13) b0_e2 = b0[2];
    end
    $display("run inst=2 latency=%0d b0=0x%05h b1=0x%05h epoch=%0d", k, b0[2], b1[2], epoch[2]);
    check("hold_latency",   32'(k),        32'd19);
    check("hold_b0_ep1",    32'(b0_e1),    32'h00800);
    check("hold_epoch_ep1", 32'(ep_e1),    32'h1);
    check("hold_b0_ep2",    32'(b0_e2),    32'h0);
    check("hold_b0_final",  32'(b0[2]),    32'h00800);
    check("hold_epoch",     32'(epoch[2]), 32'h3);
    check("hold_en_count",  g_inst[2].en_cnt - en0,   32'd6);
    check("hold_init_count", g_inst[2].init_cnt - in0, 32'd1);
    @(posedge clk); #1;
    check("hold_idle_busy", 32'(busy[2]), 32'h0);
    check("hold_idle_done", 32'(done[2]), 32'h0);
    @(posedge clk); #1;
    check("hold_restart_busy",  32'(busy[2]),  32'h1);
    check("hold_restart_epoch", 32'(epoch[2]), 32'h0);
    check("hold_restart_b0",    32'(b0[2]),    32'h0);
    start[2] = 1'b0;
    k = 1;
    while (done[2] !== 1'b1 && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    check("hold_rerun_latency", 32'(k), 32'd19);
    check("hold_done_count", g_inst[2].dcnt - d0, 32'd1);

    // Reset during the second EVAL aborts the run
    d0 = g_inst[0].dcnt;
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    check("abort_in_eval", 32'(ec_en[0]), 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_state",    32'(g_inst[0].u_dut.state_reg), 32'(IDLE));
    check("abort_busy",     32'(busy[0]),     32'h0);
    check("abort_ec_en",    32'(ec_en[0]),    32'h0);
    check("abort_x_out",    32'(x_out[0]),    32'h0);
    check("abort_y_out",    32'(y_out[0]),    32'h0);
    check("abort_mem_addr", 32'(mem_addr[0]), 32'h0);
    check("abort_b0_other", 32'(b0[3]),       32'h0);
    check("abort_b1_other", 32'(b1[4]),       32'h0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_no_done", g_inst[0].dcnt - d0, 32'd0);
    run_wait(0, 1'b0, lat);
    check("fresh_latency", 32'(lat),   32'd7);
    check("fresh_b0",      32'(b0[0]), 32'h01400);
    check("fresh_b1",      32'(b1[0]), 32'h02000);

    // ec_en and ec_init never coincide
    check("excl_0", g_inst[0].both_cnt, 32'd0);
    check("excl_1", g_inst[1].both_cnt, 32'd0);
    check("excl_2", g_inst[2].both_cnt, 32'd0);
    check("excl_3", g_inst[3].both_cnt, 32'd0);
    check("excl_4", g_inst[4].both_cnt, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
